ofdm_mapper: RTL

Transmit-side constellation mapper for the OFDM PHY. It accepts a serial stream of coded, interleaved bits and groups them into NBPSC-bit words: 1, 2, 4 or 6 bits for BPSK, QPSK, 16-QAM or 64-QAM. Each word is mapped to a Gray-coded integer I/Q constellation point. Points are emitted one subcarrier at a time and framed into OFDM symbols of NSD data subcarriers. It is the exact inverse of the receive-side demapper and feeds pilot insertion/IFFT.

---
 rtl/ofdm_mapper.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ofdm_mapper.sv
// Transmit constellation mapper: packs serial coded bits into NBPSC-bit words, maps them
// to Gray-coded integer I/Q levels and frames the points into OFDM symbols of NSD subcarriers.
module ofdm_mapper #(
  parameter int NSD   = 48,
  parameter int OUT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              rate_sel,
  input  logic                    in_bit,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic [5:0]              out_sc,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic [2:0]                bit_cnt_r;
  logic [5:0]                sreg_r;
  logic [1:0]                rate_r;
  logic [5:0]                sc_r;
  logic signed [OUT_W-1:0]   i_r;
  logic signed [OUT_W-1:0]   q_r;
  logic                      first_r;
  logic                      last_r;
  logic                      in_ready_r;
  logic                      out_valid_r;

  logic                      accept_s;
  logic                      handshake_s;
  logic                      sym_start_s;
  logic [1:0]                rate_eff_s;
  logic [2:0]                nbpsc_s;
  logic                      word_done_s;
  logic [5:0]                word_s;
  logic [5:0]                sc_next_s;
  logic signed [3:0]         map_i_s;
  logic signed [3:0]         map_q_s;

  function automatic logic [2:0] nbpsc(input logic [1:0] rate);
    case (rate)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      2'd3:    return 3'd6;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic signed [3:0] lvl2(input logic b);
    if (b) begin
      return 4'sd1;
    end else begin
      return -4'sd1;
    end
  endfunction

  // b[1] is the earlier bit of the pair
  function automatic logic signed [3:0] lvl4(input logic [1:0] b);
    case (b)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      2'b10:   return 4'sd3;
      default: return 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] lvl8(input logic [2:0] b);
    case (b)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      3'b100:  return 4'sd7;
      default: return 4'sd0;
    endcase
  endfunction

  // The first bit of a symbol uses the rate being latched on that very accept.
  assign accept_s    = in_valid && in_ready_r;
  assign handshake_s = out_valid_r && out_ready;
  assign sym_start_s = (sc_r == 6'd0) && (bit_cnt_r == 3'd0);
  assign rate_eff_s  = sym_start_s ? rate_sel : rate_r;
  assign nbpsc_s     = nbpsc(rate_eff_s);
  assign word_done_s = accept_s && ((bit_cnt_r + 3'd1) == nbpsc_s);
  assign sc_next_s   = (sc_r == 6'(NSD - 1)) ? 6'd0 : (sc_r + 6'd1);

  // Word including the bit arriving this cycle
  always_comb begin
    word_s = sreg_r;
    for (int k = 0; k < 6; k++) begin
      if (bit_cnt_r == 3'(k)) begin
        word_s[k] = in_bit;
      end else begin
        word_s[k] = sreg_r[k];
      end
    end
  end

  // Gray mapping of the completed word to I/Q levels
  always_comb begin
    map_i_s = 4'sd0;
    map_q_s = 4'sd0;
    case (rate_eff_s)
      2'd0: begin
        map_i_s = lvl2(word_s[0]);
        map_q_s = 4'sd0;
      end
      2'd1: begin
        map_i_s = lvl2(word_s[0]);
        map_q_s = lvl2(word_s[1]);
      end
      2'd2: begin
        map_i_s = lvl4({word_s[0], word_s[1]});
        map_q_s = lvl4({word_s[2], word_s[3]});
      end
      2'd3: begin
        map_i_s = lvl8({word_s[0], word_s[1], word_s[2]});
        map_q_s = lvl8({word_s[3], word_s[4], word_s[5]});
      end
      default: begin
        map_i_s = 4'sd0;
        map_q_s = 4'sd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        state_next_s = COLLECT;
      end
      COLLECT: begin
        if (word_done_s) begin
          state_next_s = EMIT;
        end else begin
          state_next_s = COLLECT;
        end
      end
      EMIT: begin
        if (handshake_s) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = EMIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and registered handshake flags (flags track the next state, so they equal a state decode)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r   <= 3'd0;
      sreg_r      <= 6'd0;
      rate_r      <= 2'd0;
      sc_r        <= 6'd0;
      i_r         <= '0;
      q_r         <= '0;
      first_r     <= 1'b1;
      last_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == COLLECT);
      out_valid_r <= (state_next_s == EMIT);
      if (accept_s) begin
        sreg_r <= word_s;
        if (sym_start_s) begin
          rate_r <= rate_sel;
        end
        if (word_done_s) begin
          bit_cnt_r <= 3'd0;
          i_r       <= OUT_W'(map_i_s);
          q_r       <= OUT_W'(map_q_s);
        end else begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
      end
      if (handshake_s) begin
        sc_r    <= sc_next_s;
        first_r <= (sc_next_s == 6'd0);
        last_r  <= (sc_next_s == 6'(NSD - 1));
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_i     = i_r;
  assign out_q     = q_r;
  assign out_sc    = sc_r;
  assign out_first = first_r;
  assign out_last  = last_r;

endmodule
